// File: rtl/rca_operand_fetch_pkg.sv
// Shared types and sizing for the RCA operand fetch path.
package rca_types;

    localparam int NUM_SRC      = 5;
    localparam int NUM_RD_PORTS = 2;
    localparam int XLEN         = 32;
    localparam int NUM_RCAS     = 4;
    localparam int ID_W         = 3;
    localparam int REG_AW       = 5;
    localparam int SEL_W        = $clog2(NUM_RCAS);
    localparam int BEATS        = (NUM_SRC + NUM_RD_PORTS - 1) / NUM_RD_PORTS;
    localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [SEL_W-1:0]                  rca_sel_t;
    typedef logic [NUM_SRC-1:0][REG_AW-1:0]    rca_src_addrs_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_ISSUE = 2'd3
    } rca_fetch_state_t;

endpackage

// File: rtl/rca_operand_fetch.sv
// Gathers the source operands of one RCA operation through a few register-file
// read ports and hands the complete operand set to the RCA unit.
module rca_operand_fetch
    import rca_types::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [SEL_W-1:0]              req_rca_sel,
    input  logic [ID_W-1:0]               req_id,
    input  logic                          flush,
    output logic [SEL_W-1:0]              cfg_rca_sel,
    input  logic [NUM_SRC*REG_AW-1:0]     cfg_src_addrs,
    output logic [NUM_RD_PORTS*REG_AW-1:0] rf_rd_addr,
    input  logic [NUM_RD_PORTS*XLEN-1:0]  rf_rd_data,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [ID_W-1:0]               issue_id,
    output logic [SEL_W-1:0]              issue_rca_sel,
    output logic [NUM_SRC*XLEN-1:0]       issue_ops,
    output logic                          busy
);

    rca_fetch_state_t                       state_q, state_d;
    logic [BEAT_W-1:0]                      beat_q, beat_d;
    rca_sel_t                               sel_q, sel_d;
    logic [ID_W-1:0]                        id_q, id_d;
    logic                                   valid_q, valid_d;
    logic                                   cap_q, cap_d;
    logic [BEAT_W-1:0]                      cap_beat_q, cap_beat_d;
    logic [NUM_RD_PORTS-1:0][REG_AW-1:0]    cap_addr_q, cap_addr_d;
    logic [NUM_SRC-1:0][XLEN-1:0]           ops_q, ops_d;

    rca_src_addrs_t                         src_s;
    logic [NUM_RD_PORTS-1:0][REG_AW-1:0]    rd_addr_s;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0]      rd_data_s;

    assign src_s     = cfg_src_addrs;
    assign rd_data_s = rf_rd_data;

    // Read-port address mux: slot s goes out on port s%P during beat s/P.
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_addr_s[p] = {REG_AW{1'b0}};
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            rd_addr_s[s % NUM_RD_PORTS] =
                ((state_q == S_READ) && (beat_q == BEAT_W'(s / NUM_RD_PORTS)))
                ? src_s[s] : rd_addr_s[s % NUM_RD_PORTS];
        end
    end

    // Next-state, beat sequencing and operand capture.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        sel_d      = sel_q;
        id_d       = id_q;
        valid_d    = valid_q;
        cap_d      = 1'b0;
        cap_beat_d = beat_q;
        cap_addr_d = rd_addr_s;

        // Data returns one cycle after its address; address x0 reads as zero.
        for (int s = 0; s < NUM_SRC; s++) begin
            if (cap_q && (cap_beat_q == BEAT_W'(s / NUM_RD_PORTS))) begin
                if (cap_addr_q[s % NUM_RD_PORTS] == {REG_AW{1'b0}}) begin
                    ops_d[s] = {XLEN{1'b0}};
                end else begin
                    ops_d[s] = rd_data_s[s % NUM_RD_PORTS];
                end
            end else begin
                ops_d[s] = ops_q[s];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    sel_d   = req_rca_sel;
                    id_d    = req_id;
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                cap_d = !flush;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (flush || issue_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= {BEAT_W{1'b0}};
            sel_q      <= {SEL_W{1'b0}};
            id_q       <= {ID_W{1'b0}};
            valid_q    <= 1'b0;
            cap_q      <= 1'b0;
            cap_beat_q <= {BEAT_W{1'b0}};
            cap_addr_q <= '0;
            ops_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            sel_q      <= sel_d;
            id_q       <= id_d;
            valid_q    <= valid_d;
            cap_q      <= cap_d;
            cap_beat_q <= cap_beat_d;
            cap_addr_q <= cap_addr_d;
            ops_q      <= ops_d;
        end
    end

    // Flush must suppress an issue in the very cycle it arrives.
    assign issue_valid   = valid_q && !flush;
    assign req_ready     = (state_q == S_IDLE) && !flush;
    assign busy          = (state_q != S_IDLE);
    assign cfg_rca_sel   = sel_q;
    assign issue_rca_sel = sel_q;
    assign issue_id      = id_q;
    assign issue_ops     = ops_q;
    assign rf_rd_addr    = rd_addr_s;

endmodule
